// File: rtl/adpcm_enc_packer.sv
// ADPCM encoder front end: hands PCM samples to the codec over its toggle/ack
// handshake, packs the returned 4-bit codes two per byte and buffers the bytes.
module adpcm_enc_packer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     enable,
   input  logic                     pcm_valid,
   output logic                     pcm_ready,
   input  logic [15:0]              pcm_data,
   input  logic                     flush,
   output logic                     byte_valid,
   input  logic                     byte_ready,
   output logic [7:0]               byte_data,
   output logic                     codec_req,
   input  logic                     codec_ack,
   output logic                     codec_sel_rx,
   output logic [15:0]              codec_pcm,
   input  logic [3:0]               codec_adpcm,
   output logic                     half_pending,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     err_timeout
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_PACK} state_t;
   state_t state, state_nxt;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [3:0]    held, code;
   logic [CW-1:0] cnt;
   logic          not_full, flush_take, accept, pack_push, push, pop, in_wait, timed_out;
   logic [7:0]    push_data;

   assign codec_sel_rx = 1'b0;
   assign not_full     = fifo_level < LW'(DEPTH);
   assign flush_take   = enable & (state == S_IDLE) & flush & half_pending & not_full;
   // flush wins over a sample arriving in the same cycle
   assign pcm_ready    = enable & (state == S_IDLE) & not_full & ~flush_take;
   assign accept       = pcm_valid & pcm_ready;
   assign pack_push    = (state == S_PACK) & half_pending;
   assign push         = flush_take | pack_push;
   assign push_data    = flush_take ? {4'h0, held} : {code, held};
   assign pop          = byte_ready & byte_valid;
   assign in_wait      = (state == S_WAIT_LO) | (state == S_WAIT_HI);
   assign timed_out    = cnt == CW'(TIMEOUT - 1);
   assign byte_valid   = fifo_level != '0;
   assign byte_data    = byte_valid ? mem[rd_ptr] : 8'h00;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (accept) state_nxt = S_ISSUE;
         S_ISSUE:   state_nxt = S_WAIT_LO;
         S_WAIT_LO: if (!codec_ack) state_nxt = S_WAIT_HI;
                    else if (timed_out) state_nxt = S_IDLE;
         S_WAIT_HI: if (codec_ack) state_nxt = S_PACK;
                    else if (timed_out) state_nxt = S_IDLE;
         S_PACK:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
      if (!enable) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         codec_pcm    <= '0;
         codec_req    <= 1'b0;
         cnt          <= '0;
         err_timeout  <= 1'b0;
         code         <= '0;
         held         <= '0;
         half_pending <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_level   <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (!enable) begin
         codec_pcm    <= '0;
         codec_req    <= 1'b0;
         cnt          <= '0;
         err_timeout  <= 1'b0;
         code         <= '0;
         held         <= '0;
         half_pending <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_level   <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (accept) codec_pcm <= pcm_data;
         if (state == S_ISSUE) codec_req <= ~codec_req;

         // counter restarts on every state change, so each ack phase gets its own budget
         if (state_nxt != state) cnt <= '0;
         else if (in_wait)       cnt <= cnt + CW'(1);
         if (in_wait && state_nxt == S_IDLE) err_timeout <= 1'b1;

         if (state == S_WAIT_HI && codec_ack) code <= codec_adpcm;

         if (state == S_PACK) begin
            if (!half_pending) begin
               held         <= code;
               half_pending <= 1'b1;
            end else begin
               half_pending <= 1'b0;
            end
         end
         if (flush_take) half_pending <= 1'b0;

         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end
endmodule

// File: doc/adpcm_enc_packer.md
Name: adpcm_enc_packer

Overview:
Encoder-side front end for the ADPCM codec. It accepts 16-bit PCM samples over valid/ready and drives the codec's toggle-request handshake in encode mode (sel_rx low). It collects the returned 4-bit codes, packs two codes per byte (first code in the low nibble) and buffers the bytes in a small FIFO for the byte-stream consumer.

Parameters:
DEPTH, 4, output byte FIFO depth in entries (power of two, >=2)
TIMEOUT, 64, maximum cycles to wait for each codec ack phase before aborting

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
enable  in  1  block enable; low = synchronous clear to reset state
pcm_valid  in  1  input sample valid
pcm_ready  out  1  input sample accepted when valid&ready
pcm_data  in  16  signed PCM sample
flush  in  1  level request: emit pending half-byte
byte_valid  out  1  FIFO head valid
byte_ready  in  1  consumer pop
byte_data  out  8  FIFO head byte
codec_req  out  1  toggle request to codec
codec_ack  in  1  codec idle indicator (high = idle)
codec_sel_rx  out  1  tied low (encode)
codec_pcm  out  16  registered sample presented to codec
codec_adpcm  in  4  code returned by codec
half_pending  out  1  one nibble held, byte incomplete
fifo_level  out  $clog2(DEPTH)+1  bytes stored
err_timeout  out  1  sticky codec timeout flag

Behaviour:
- Reset (rstn low) or enable low: all regs 0. Outputs: pcm_ready=0, codec_req=0, codec_pcm=0, byte_valid=0, byte_data=0, half_pending=0, fifo_level=0, err_timeout=0. FSM goes to S_IDLE. codec_sel_rx is constant 0.
- FSM states: S_IDLE, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_PACK.
- S_IDLE: pcm_ready = (fifo_level<DEPTH) & ~flush_take, combinational.
  - On accept: codec_pcm<=pcm_data, go S_ISSUE.
  - flush_take = flush & half_pending & (fifo_level<DEPTH). It pushes {4'h0, held nibble}, clears half_pending and stays in S_IDLE. Flush has priority over a same-cycle sample.
  - flush with no pending nibble is a no-op.
- S_ISSUE: codec_req<=~codec_req, go S_WAIT_LO. Exactly one toggle per sample.
- S_WAIT_LO: wait for codec_ack==0, then go S_WAIT_HI.
- S_WAIT_HI: wait for codec_ack==1. On that cycle capture codec_adpcm and go S_PACK.
- Timeout: a counter cleared on entry to each wait state. Reaching TIMEOUT sets err_timeout (sticky until reset/enable low), drops the sample without a push and returns to S_IDLE. The pending nibble is kept.
- S_PACK:
  - If ~half_pending: hold the code in the low nibble, set half_pending.
  - Else: push {code, held} to the FIFO and clear half_pending.
  - Go to S_IDLE.
  - Space is guaranteed because pcm_ready required fifo_level<DEPTH.
- Latency: sample accept at edge N → codec_req toggles at edge N+1. Code capture occurs on the first codec_ack-high cycle after the low phase; the push is on the following edge. Then S_IDLE, so ≥1 idle cycle per sample.
- FIFO:
  - Circular, registered pointers, wrap at DEPTH.
  - byte_valid = fifo_level!=0; byte_data = head entry (reads 0 when empty).
  - Push and pop in the same cycle: fifo_level unchanged.
  - Pop when empty: ignored.
  - byte_data stable while byte_valid & ~byte_ready.
- Mid-operation enable low or reset: the transaction is abandoned and FIFO contents are lost. codec_req returns to 0, matching the codec's own clear of its request history.

Test Plan:
- Reset then 2 samples (0x1000, 0xF000) with a codec stub returning 0x3 then 0xA after 7-cycle busy → one byte 0xA3, fifo_level=1, codec_req toggled twice, half_pending 1 then 0.
- 3 samples (codes 0x1, 0x2, 0x5) then flush pulse → bytes 0x21 then 0x05 in order, half_pending=0.
- byte_ready held low, DEPTH=4, 10 samples → after 8 codes fifo_level=4, pcm_ready=0. Pop one → exactly one further sample pair accepted. No byte lost or duplicated.
- Stub never drops codec_ack for 64 cycles → err_timeout=1, FSM in S_IDLE, no push. Next sample with a responsive stub completes normally, err_timeout stays 1.
- flush and pcm_valid asserted together with half_pending=1 → pad byte pushed first, pcm_ready=0 that cycle, sample accepted the next cycle.
- enable dropped in S_WAIT_HI with 2 bytes in the FIFO → next cycle fifo_level=0, byte_valid=0, codec_req=0, half_pending=0, pcm_ready=0. After re-enable, pcm_ready=1.
